fhg_tx_arbiter: RTL

FHG_TX_ARBITER -- requirements
Module: fhg_tx_arbiter

---
 rtl/fhg_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fhg_tx_arbiter.sv
// Two-requester AXIS packet arbiter with round-robin ties and a per-packet beat cap (optional stats: FHG_TX_ARB_STATS_EN).
// Latency: zero; the owner's stream passes combinationally, with one idle bubble cycle between packets.
// Backpressure: owner tready follows m_tready; no grant is issued while tx_af is high; over-length tails are drained.
module fhg_tx_arbiter #(
    parameter int DATA_WIDTH = 1024,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_tkeep,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    input  logic                  s0_tuser,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_tkeep,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    input  logic                  s1_tuser,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  m_tready,
    input  logic                  tx_af,
    output logic [1:0]            grant
`ifdef FHG_TX_ARB_STATS_EN
    ,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1,
    output logic [31:0]           trunc_cnt
`endif
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DROP0, DROP1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
    logic            last_srv, last_srv_nxt;

    // Owner index and its muxed stream; only meaningful outside IDLE.
    logic                  owner;
    logic [DATA_WIDTH-1:0] o_tdata;
    logic [KEEP_WIDTH-1:0] o_tkeep;
    logic                  o_tvalid, o_tlast, o_tuser;
    logic                  at_limit;

    assign owner    = (state == GRANT1) || (state == DROP1);
    assign o_tdata  = owner ? s1_tdata  : s0_tdata;
    assign o_tkeep  = owner ? s1_tkeep  : s0_tkeep;
    assign o_tvalid = owner ? s1_tvalid : s0_tvalid;
    assign o_tlast  = owner ? s1_tlast  : s0_tlast;
    assign o_tuser  = owner ? s1_tuser  : s0_tuser;
    // The beat about to be accepted is the last one a packet may carry.
    assign at_limit = (beat_cnt == CW'(MAX_BEATS - 1));

    // Next-state, beat counting and the combinational datapath/handshake mux.
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        last_srv_nxt = last_srv;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tvalid     = 1'b0;
        m_tlast      = 1'b0;
        m_tuser      = 1'b0;
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;
        grant        = 2'b00;
        case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (!tx_af) begin
                    // Port 0 wins a tie only when port 1 was served last.
                    if (s0_tvalid && (!s1_tvalid || last_srv))
                        state_nxt = GRANT0;
                    else if (s1_tvalid)
                        state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                grant     = owner ? 2'b10 : 2'b01;
                m_tdata   = o_tdata;
                m_tkeep   = o_tkeep;
                m_tvalid  = o_tvalid;
                m_tlast   = o_tlast | at_limit;
                m_tuser   = o_tuser | (at_limit & ~o_tlast);
                s0_tready = ~owner & m_tready;
                s1_tready = owner & m_tready;
                if (o_tvalid && m_tready) begin
                    if (o_tlast) begin
                        state_nxt    = IDLE;
                        last_srv_nxt = owner;
                    end else if (at_limit) begin
                        state_nxt = owner ? DROP1 : DROP0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            DROP0, DROP1: begin
                grant     = owner ? 2'b10 : 2'b01;
                s0_tready = ~owner;
                s1_tready = owner;
                if (o_tvalid && o_tlast) begin
                    state_nxt    = IDLE;
                    last_srv_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are forced quiet for the whole reset window, not just after it.
        if (rst) begin
            m_tvalid  = 1'b0;
            m_tlast   = 1'b0;
            m_tuser   = 1'b0;
            s0_tready = 1'b0;
            s1_tready = 1'b0;
            grant     = 2'b00;
        end
    end

    // State, beat counter and last-served register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_srv <= 1'b1;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            last_srv <= last_srv_nxt;
        end
    end

`ifdef FHG_TX_ARB_STATS_EN
    logic acc_beat, pkt_done, trunc_evt;

    // A packet completes on its tlast beat or on the capped beat that truncates it.
    always_comb begin
        acc_beat  = ((state == GRANT0) || (state == GRANT1)) && o_tvalid && m_tready;
        pkt_done  = acc_beat && (o_tlast || at_limit);
        trunc_evt = acc_beat && !o_tlast && at_limit;
    end

    // Free-running statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0  <= '0;
            pkt_cnt1  <= '0;
            trunc_cnt <= '0;
        end else begin
            if (pkt_done && !owner) pkt_cnt0 <= pkt_cnt0 + 32'd1;
            if (pkt_done && owner)  pkt_cnt1 <= pkt_cnt1 + 32'd1;
            if (trunc_evt)          trunc_cnt <= trunc_cnt + 32'd1;
        end
    end
`endif

endmodule
